// File: rtl/bus_pkg.sv
// bus_pkg: shared state encoding, mode constants and counter sizing for the serial bus slave port
package bus_pkg;
  typedef enum logic [2:0] {IDLE, ADDR, WDATA, WRITE, RREQ, RWAIT, RDATA} state_t;
  localparam logic MODE_READ  = 1'b0;
  localparam logic MODE_WRITE = 1'b1;
  function automatic int cnt_width(input int a, input int b);
    return $clog2(a > b ? a : b) + 1;
  endfunction
endpackage

// File: rtl/serial_shift_reg.sv
// serial_shift_reg: indexed serial-in / parallel-load register with gated serial-out at a bit index
module serial_shift_reg #(
  parameter int W  = 8,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          i_sin_en,
  input  logic          i_sin,
  input  logic [CW-1:0] i_idx,
  input  logic          i_load,
  input  logic [W-1:0]  i_pdata,
  input  logic          i_sout_en,
  output logic [W-1:0]  o_q,
  output logic          o_sout
);
  logic [W-1:0] w_sel;
  logic [W-1:0] w_shift;
  assign w_sel   = W'(1) << i_idx;
  assign w_shift = o_q >> i_idx;
  assign o_sout  = i_sout_en & w_shift[0];
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) o_q <= '0;
    else if (i_load) o_q <= i_pdata;
    else if (i_sin_en) o_q <= i_sin ? (o_q | w_sel) : (o_q & ~w_sel);
endmodule

// File: rtl/bus_slave_port.sv
// bus_slave_port: deserialises a serial bus access, performs one local memory access, serialises read data back
module bus_slave_port
  import bus_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  swdata,
  input  logic                  smode,
  input  logic                  smvalid,
  output logic                  srdata,
  output logic                  ssvalid,
  output logic                  sready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_wen,
  output logic                  mem_ren,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);
  localparam int CW = cnt_width(ADDR_WIDTH, DATA_WIDTH);
  localparam logic [CW-1:0] A_LAST = CW'(ADDR_WIDTH - 1);
  localparam logic [CW-1:0] D_LAST = CW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0] D_END  = CW'(DATA_WIDTH);
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_mode;
  logic          w_addr_en;
  logic          w_data_en;
  logic          w_sout_en;
  logic          w_addr_sout;
  logic          w_data_sout;
  logic          w_sout;
  assign w_addr_en = smvalid & (r_state == IDLE || r_state == ADDR);
  assign w_data_en = smvalid & (r_state == WDATA);
  assign w_sout_en = (r_state == RDATA) && (r_cnt != D_END);
  // address register never serialises out; its gated output is always zero
  assign w_sout    = w_data_sout | w_addr_sout;
  serial_shift_reg #(.W(ADDR_WIDTH), .CW(CW)) u_addr (
    .clk      (clk),
    .rstn     (rstn),
    .i_sin_en (w_addr_en),
    .i_sin    (swdata),
    .i_idx    (r_cnt),
    .i_load   (1'b0),
    .i_pdata  ('0),
    .i_sout_en(1'b0),
    .o_q      (mem_addr),
    .o_sout   (w_addr_sout)
  );
  serial_shift_reg #(.W(DATA_WIDTH), .CW(CW)) u_data (
    .clk      (clk),
    .rstn     (rstn),
    .i_sin_en (w_data_en),
    .i_sin    (swdata),
    .i_idx    (r_cnt),
    .i_load   (r_state == RWAIT),
    .i_pdata  (mem_rdata),
    .i_sout_en(w_sout_en),
    .o_q      (mem_wdata),
    .o_sout   (w_data_sout)
  );
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_mode  <= MODE_READ;
      sready  <= 1'b1;
      ssvalid <= 1'b0;
      srdata  <= 1'b0;
      mem_wen <= 1'b0;
      mem_ren <= 1'b0;
    end else begin
      mem_wen <= 1'b0;
      mem_ren <= 1'b0;
      case (r_state)
        IDLE: if (smvalid) begin
          r_mode  <= smode;
          r_cnt   <= CW'(1);
          sready  <= 1'b0;
          r_state <= ADDR;
        end
        ADDR: if (smvalid) begin
          if (r_cnt == A_LAST) begin
            r_cnt   <= '0;
            r_state <= r_mode == MODE_WRITE ? WDATA : RREQ;
            mem_ren <= r_mode == MODE_READ;
          end else r_cnt <= r_cnt + CW'(1);
        end
        WDATA: if (smvalid) begin
          if (r_cnt == D_LAST) begin
            r_cnt   <= '0;
            r_state <= WRITE;
            mem_wen <= 1'b1;
          end else r_cnt <= r_cnt + CW'(1);
        end
        WRITE: begin
          sready  <= 1'b1;
          r_state <= IDLE;
        end
        RREQ:  r_state <= RWAIT;
        RWAIT: r_state <= RDATA;
        RDATA: if (r_cnt == D_END) begin
          r_cnt   <= '0;
          ssvalid <= 1'b0;
          srdata  <= 1'b0;
          sready  <= 1'b1;
          r_state <= IDLE;
        end else begin
          r_cnt   <= r_cnt + CW'(1);
          ssvalid <= 1'b1;
          srdata  <= w_sout;
        end
        default: r_state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_bus_slave_port.sv
// tb_bus_slave_port: directed write/read/gap/glitch/reset/ignored-input checks against hand-computed values
module tb_bus_slave_port;
  logic clk = 0, rstn = 0, swdata = 0, smode = 0, smvalid = 0;
  logic srdata, ssvalid, sready, mem_wen, mem_ren;
  logic [11:0] mem_addr, wa, ra;
  logic [7:0] mem_wdata, wd, rbits;
  logic [7:0] mem_rdata = 8'hEE, rd_val = 8'h00;
  int total = 0, bad = 0, cyc = 0;
  int wen_cnt, wen_cyc, ren_cnt, rn, sv_first, sv_last, e_last;
  always #5 clk = ~clk;
  bus_slave_port #(.ADDR_WIDTH(12), .DATA_WIDTH(8)) dut (
    .clk(clk), .rstn(rstn), .swdata(swdata), .smode(smode), .smvalid(smvalid),
    .srdata(srdata), .ssvalid(ssvalid), .sready(sready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wen(mem_wen), .mem_ren(mem_ren),
    .mem_rdata(mem_rdata)
  );
  always @(posedge clk) cyc++;
  always @(posedge clk) mem_rdata <= mem_ren ? rd_val : 8'hEE;
  always @(negedge clk) if (rstn) begin
    if (mem_wen) begin wen_cnt++; wen_cyc = cyc; wa = mem_addr; wd = mem_wdata; end
    if (mem_ren) begin ren_cnt++; ra = mem_addr; end
    if (ssvalid) begin
      if (rn < 8) rbits[3'(rn)] = srdata;
      if (rn == 0) sv_first = cyc;
      sv_last = cyc;
      rn++;
    end
  end
  task chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task clr();
    wen_cnt = 0; ren_cnt = 0; rn = 0; rbits = 0; sv_first = -1; sv_last = -1; wen_cyc = -1;
  endtask
  task send(input logic [11:0] v, input int n, input logic m, input bit gap, input int flip);
    for (int i = 0; i < n; i++) begin
      if (gap) begin @(negedge clk); smvalid = 0; swdata = ~swdata; end
      @(negedge clk); swdata = v[i]; smode = (i >= flip) ? ~m : m; smvalid = 1;
    end
    e_last = cyc + 1;
  endtask
  task do_write(input logic [11:0] a, input logic [7:0] d, input bit gap, input int flip, input string tag);
    clr();
    send(a, 12, 1'b1, gap, flip);
    send({4'h0, d}, 8, 1'b1, gap, 99);
    @(negedge clk); smvalid = 0;
    chk({tag, "_wen_on"}, mem_wen, 1);
    chk({tag, "_addr"}, mem_addr, a);
    chk({tag, "_wdata"}, mem_wdata, d);
    chk({tag, "_busy"}, sready, 0);
    @(negedge clk);
    chk({tag, "_wen_off"}, mem_wen, 0);
    chk({tag, "_ready"}, sready, 1);
    chk({tag, "_wen_cnt"}, wen_cnt, 1);
    chk({tag, "_wen_cyc"}, wen_cyc, e_last);
  endtask
  task do_read(input logic [11:0] a, input logic [7:0] d, input bit pulses, input string tag);
    clr();
    rd_val = d;
    send(a, 12, 1'b0, 0, 99);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); smvalid = pulses && (i % 2 == 1); swdata = 1; smode = 1;
    end
    smvalid = 0;
    repeat (4) @(negedge clk);
    chk({tag, "_ren_cnt"}, ren_cnt, 1);
    chk({tag, "_raddr"}, ra, a);
    chk({tag, "_nbits"}, rn, 8);
    chk({tag, "_rbits"}, rbits, d);
    chk({tag, "_sv_first"}, sv_first, e_last + 3);
    chk({tag, "_sv_last"}, sv_last, e_last + 10);
    chk({tag, "_ready"}, sready, 1);
    chk({tag, "_sv_off"}, ssvalid, 0);
    chk({tag, "_no_wen"}, wen_cnt, 0);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_srdata", srdata, 0);
    chk("rst_ssvalid", ssvalid, 0);
    chk("rst_sready", sready, 1);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_wen", mem_wen, 0);
    chk("rst_ren", mem_ren, 0);
    rstn = 1;
    do_write(12'h5A3, 8'hC7, 0, 99, "w1");
    do_read(12'h0FF, 8'h3C, 0, "r1");
    do_write(12'h001, 8'h80, 1, 99, "gap");
    do_write(12'h2B4, 8'h5E, 0, 6, "glitch");
    do_read(12'h123, 8'h96, 1, "ign");
    clr();
    rd_val = 8'hA5;
    send(12'h456, 12, 1'b0, 0, 99);
    @(negedge clk); smvalid = 0;
    for (int i = 0; i < 20 && cyc != e_last + 6; i++) @(negedge clk);
    chk("mid_reach", cyc, e_last + 6);
    chk("mid_sv_pre", ssvalid, 1);
    chk("mid_bit3_pre", srdata, 0);
    rstn = 0;
    #1;
    chk("mid_sv", ssvalid, 0);
    chk("mid_ready", sready, 1);
    chk("mid_addr", mem_addr, 0);
    chk("mid_ren_cnt", ren_cnt, 1);
    @(negedge clk); rstn = 1;
    do_write(12'h7FF, 8'h11, 0, 99, "post");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
